pipe_hazard_ctrl: RTL and testbench

- Central sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Generates per-stage enable and flush controls, and EX-stage and ID-stage forwarding selects.
- Handles load-use stalls, taken-branch flushes (branch resolves in MEM), data-memory wait freezes, and a debug halt/step/resume FSM.
- Sits beside the CPU top; every pipeline register consumes one en/flush pair from it.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_fwd_unit.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: forwarding
// select encodings, debug FSM states and the default drain length.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Advancing cycles to empty ID/EX, EX/MEM, MEM/WB and finish the WB write
  localparam int DRAIN_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    HALTED  = 2'd2,
    STEP    = 2'd3
  } dbg_state_e;

  // A producer forwards only when it writes a non-x0 register matching the source
  function automatic logic fwd_hit(input logic we, input logic [4:0] wr,
                                   input logic [4:0] rs);
    return we & (wr != 5'd0) & (wr == rs);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational operand bypass selection for the EX stage (from EX/MEM or
// MEM/WB) and the ID stage register read (from the WB write data).
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_exmem_WriteReg,
  input  logic       i_exmem_RegWrite,
  input  logic [4:0] i_memwb_WriteReg,
  input  logic       i_memwb_RegWrite,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_id_fwd_a,
  output logic       o_id_fwd_b
);

  // EX/MEM holds the younger result, so it wins over MEM/WB
  always_comb begin
    o_fwd_a = FWD_RF;
    if (fwd_hit(i_exmem_RegWrite, i_exmem_WriteReg, i_ex_rs1))      o_fwd_a = FWD_EXMEM;
    else if (fwd_hit(i_memwb_RegWrite, i_memwb_WriteReg, i_ex_rs1)) o_fwd_a = FWD_MEMWB;
    o_fwd_b = FWD_RF;
    if (fwd_hit(i_exmem_RegWrite, i_exmem_WriteReg, i_ex_rs2))      o_fwd_b = FWD_EXMEM;
    else if (fwd_hit(i_memwb_RegWrite, i_memwb_WriteReg, i_ex_rs2)) o_fwd_b = FWD_MEMWB;
  end

  assign o_id_fwd_a = i_id_use_rs1 & fwd_hit(i_memwb_RegWrite, i_memwb_WriteReg, i_id_rs1);
  assign o_id_fwd_b = i_id_use_rs2 & fwd_hit(i_memwb_RegWrite, i_memwb_WriteReg, i_id_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencing controller for the 5-stage pipeline: per-stage enables
// and flushes, load-use stall, branch flush, data-memory freeze, debug
// halt/step/resume and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       idex_WriteReg,
  input  logic             idex_MemRead,
  input  logic             idex_RegWrite,
  input  logic [4:0]       exmem_WriteReg,
  input  logic             exmem_RegWrite,
  input  logic [4:0]       memwb_WriteReg,
  input  logic             memwb_RegWrite,
  input  logic             mem_PCSrc,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             dbg_halt_req,
  input  logic             dbg_step_req,
  input  logic             dbg_resume_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_fwd_a,
  output logic             id_fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  dbg_state_e       r_state;
  logic [DW-1:0]    r_drain;
  logic             r_halted;
  logic [4:0]       r_ex_rs1, r_ex_rs2;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_memwait, w_loaduse, w_drain_adv;
  logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic w_ifid_flush, w_idex_flush, w_exmem_flush;

  assign w_memwait = dmem_req & ~dmem_ready;
  assign w_loaduse = idex_MemRead & idex_RegWrite & (idex_WriteReg != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == idex_WriteReg)) |
                      (id_use_rs2 & (id_rs2 == idex_WriteReg)));
  // Drain progresses on any non-frozen cycle except a load-use stall (a
  // coincident branch overrides the stall, so that cycle still advances)
  assign w_drain_adv = ~w_memwait & ~(w_loaduse & ~mem_PCSrc);

  // Stage control: memory freeze > branch flush > load-use > debug state
  always_comb begin
    w_pc_en = 1'b1; w_ifid_en = 1'b1; w_idex_en = 1'b1;
    w_exmem_en = 1'b1; w_memwb_en = 1'b1;
    w_ifid_flush = 1'b0; w_idex_flush = 1'b0; w_exmem_flush = 1'b0;
    if (w_memwait) begin
      w_pc_en = 1'b0; w_ifid_en = 1'b0; w_idex_en = 1'b0;
      w_exmem_en = 1'b0; w_memwb_en = 1'b0;
    end else if (mem_PCSrc) begin
      w_ifid_flush = 1'b1; w_idex_flush = 1'b1; w_exmem_flush = 1'b1;
    end else if (w_loaduse) begin
      w_pc_en = 1'b0; w_ifid_en = 1'b0; w_idex_flush = 1'b1;
    end else begin
      case (r_state)
        HALTING: begin
          // PC holds so the discarded fetch is refetched on resume
          w_pc_en = 1'b0; w_ifid_flush = 1'b1;
        end
        HALTED: begin
          w_pc_en = 1'b0; w_ifid_en = 1'b0; w_idex_en = 1'b0;
          w_exmem_en = 1'b0; w_memwb_en = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Debug FSM with drain counter; requests are taken even in frozen cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= RUN;
      r_drain  <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        RUN: if (dbg_halt_req) begin
          r_state <= HALTING;
          r_drain <= '0;
        end
        HALTING: if (w_drain_adv) begin
          if (r_drain == DRAIN_LAST) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        HALTED: begin
          if (dbg_resume_req) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end else if (dbg_step_req) begin
            r_state  <= STEP;
            r_halted <= 1'b0;
          end
        end
        STEP: if (!w_memwait) begin
          r_state <= HALTING;
          r_drain <= '0;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Source registers of the instruction currently in EX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_rs1 <= 5'd0;
      r_ex_rs2 <= 5'd0;
    end else if (w_idex_flush) begin
      r_ex_rs1 <= 5'd0;
      r_ex_rs2 <= 5'd0;
    end else if (w_idex_en) begin
      r_ex_rs1 <= id_use_rs1 ? id_rs1 : 5'd0;
      r_ex_rs2 <= id_use_rs2 ? id_rs2 : 5'd0;
    end
  end

  // Saturating count of stalled cycles, only while running normally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall_cnt <= '0;
    else if ((r_state == RUN) && (!w_pc_en || w_memwait) && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  pipe_fwd_unit u_fwd (
    .i_ex_rs1         (r_ex_rs1),
    .i_ex_rs2         (r_ex_rs2),
    .i_id_rs1         (id_rs1),
    .i_id_rs2         (id_rs2),
    .i_id_use_rs1     (id_use_rs1),
    .i_id_use_rs2     (id_use_rs2),
    .i_exmem_WriteReg (exmem_WriteReg),
    .i_exmem_RegWrite (exmem_RegWrite),
    .i_memwb_WriteReg (memwb_WriteReg),
    .i_memwb_RegWrite (memwb_RegWrite),
    .o_fwd_a          (fwd_a),
    .o_fwd_b          (fwd_b),
    .o_id_fwd_a       (id_fwd_a),
    .o_id_fwd_b       (id_fwd_b)
  );

  assign pc_en       = w_pc_en;
  assign ifid_en     = w_ifid_en;
  assign idex_en     = w_idex_en;
  assign exmem_en    = w_exmem_en;
  assign memwb_en    = w_memwb_en;
  assign ifid_flush  = w_ifid_flush;
  assign idex_flush  = w_idex_flush;
  assign exmem_flush = w_exmem_flush;
  assign halted      = r_halted;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Each cycle the stimulus pushes its
// hand-computed expectation; a monitor pops and compares on the falling edge.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, idex_WriteReg = '0;
  logic [4:0] exmem_WriteReg = '0, memwb_WriteReg = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, idex_MemRead = 0, idex_RegWrite = 0;
  logic exmem_RegWrite = 0, memwb_RegWrite = 0, mem_PCSrc = 0;
  logic dmem_req = 0, dmem_ready = 0;
  logic dbg_halt_req = 0, dbg_step_req = 0, dbg_resume_req = 0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush;
  logic [1:0] fwd_a, fwd_b;
  logic id_fwd_a, id_fwd_b, halted;
  logic [15:0] stall_count;

  pipe_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .idex_WriteReg(idex_WriteReg), .idex_MemRead(idex_MemRead), .idex_RegWrite(idex_RegWrite),
    .exmem_WriteReg(exmem_WriteReg), .exmem_RegWrite(exmem_RegWrite),
    .memwb_WriteReg(memwb_WriteReg), .memwb_RegWrite(memwb_RegWrite),
    .mem_PCSrc(mem_PCSrc), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .dbg_halt_req(dbg_halt_req), .dbg_step_req(dbg_step_req), .dbg_resume_req(dbg_resume_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b),
    .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] M_EN = 4'b0001, M_FW = 4'b0010, M_H = 4'b0100, M_SC = 4'b1000;

  typedef struct {
    string       nm;
    logic [3:0]  m;
    logic [4:0]  en;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0]  fl;   // {ifid, idex, exmem}
    logic [1:0]  fa, fb;
    logic        ida, idb, h;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: compare the expectation queued for this cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) begin
        cmp({e.nm, ".en"}, 16'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 16'(e.en));
        cmp({e.nm, ".flush"}, 16'({ifid_flush, idex_flush, exmem_flush}), 16'(e.fl));
      end
      if (e.m[1]) begin
        cmp({e.nm, ".fwd"}, 16'({fwd_a, fwd_b}), 16'({e.fa, e.fb}));
        cmp({e.nm, ".id_fwd"}, 16'({id_fwd_a, id_fwd_b}), 16'({e.ida, e.idb}));
      end
      if (e.m[2]) cmp({e.nm, ".halted"}, 16'(halted), 16'(e.h));
      if (e.m[3]) cmp({e.nm, ".stall_count"}, stall_count, e.sc);
    end
  end

  task automatic push(input string nm, input logic [3:0] m, input logic [4:0] en,
                      input logic [2:0] fl, input logic [1:0] fa, input logic [1:0] fb,
                      input logic ida, input logic idb, input logic h, input logic [15:0] sc);
    exp_t e;
    e.nm = nm; e.m = m; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb;
    e.ida = ida; e.idb = idb; e.h = h; e.sc = sc;
    q.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic [3:0] m, input logic [4:0] en,
                     input logic [2:0] fl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic ida, input logic idb, input logic h, input logic [15:0] sc);
    push(nm, m, en, fl, fa, fb, ida, idb, h, sc);
    @(posedge clk); #1;
  endtask

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    idex_WriteReg = 0; idex_MemRead = 0; idex_RegWrite = 0;
    exmem_WriteReg = 0; exmem_RegWrite = 0; memwb_WriteReg = 0; memwb_RegWrite = 0;
    mem_PCSrc = 0; dmem_req = 0; dmem_ready = 0;
    dbg_halt_req = 0; dbg_step_req = 0; dbg_resume_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    cyc("reset", 4'b1111, 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0, 0, 16'd0);
    reset = 1'b0;

    // Load-use on rs1, then the dependent instruction picks up MEM/WB
    idex_MemRead = 1; idex_RegWrite = 1; idex_WriteReg = 5; id_rs1 = 5; id_use_rs1 = 1;
    cyc("lu_stall", M_EN | M_FW, 5'b00111, 3'b010, 2'b00, 2'b00, 0, 0, 0, 0);
    idex_MemRead = 0; idex_RegWrite = 0; idex_WriteReg = 0; exmem_RegWrite = 1; exmem_WriteReg = 5;
    cyc("lu_bubble", M_EN | M_FW | M_SC, 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0, 0, 16'd1);
    exmem_RegWrite = 0; exmem_WriteReg = 0; memwb_RegWrite = 1; memwb_WriteReg = 5;
    cyc("lu_fwd", M_EN | M_FW, 5'b11111, 3'b000, 2'b01, 2'b00, 1, 0, 0, 0);
    memwb_RegWrite = 0; memwb_WriteReg = 0;
    idex_MemRead = 1; idex_RegWrite = 1; idex_WriteReg = 0; id_rs1 = 0; id_use_rs1 = 1;
    cyc("lu_x0", M_EN | M_FW, 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0);
    idex_WriteReg = 9; id_rs2 = 9; id_use_rs2 = 1; id_use_rs1 = 0;
    cyc("lu_rs2", M_EN, 5'b00111, 3'b010, 0, 0, 0, 0, 0, 0);
    id_use_rs2 = 0;
    cyc("lu_rs2_unused", M_EN, 5'b11111, 3'b000, 0, 0, 0, 0, 0, 0);

    // Forwarding priority on operand B
    idex_MemRead = 0; idex_RegWrite = 0; idex_WriteReg = 0; id_rs2 = 7; id_use_rs2 = 1;
    cyc("fw_load", M_EN, 5'b11111, 3'b000, 0, 0, 0, 0, 0, 0);
    exmem_RegWrite = 1; exmem_WriteReg = 7; memwb_RegWrite = 1; memwb_WriteReg = 7;
    cyc("fw_prio", M_EN | M_FW, 5'b11111, 3'b000, 2'b00, 2'b10, 0, 1, 0, 0);
    exmem_RegWrite = 0; id_rs2 = 0;
    cyc("fw_memwb", M_FW, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0);
    exmem_RegWrite = 1; exmem_WriteReg = 0; memwb_WriteReg = 0;
    cyc("fw_x0", M_FW, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    clr();

    // Taken branch overrides a coincident load-use hazard, for one cycle only
    mem_PCSrc = 1; idex_MemRead = 1; idex_RegWrite = 1; idex_WriteReg = 5; id_rs1 = 5; id_use_rs1 = 1;
    cyc("br", M_EN, 5'b11111, 3'b111, 0, 0, 0, 0, 0, 0);
    clr();
    cyc("br_done", M_EN, 5'b11111, 3'b000, 0, 0, 0, 0, 0, 0);

    // Memory wait freezes everything for three cycles, even over a branch
    dmem_req = 1;
    cyc("mw1", M_EN | M_SC, 5'b00000, 3'b000, 0, 0, 0, 0, 0, 16'd2);
    cyc("mw2", M_EN, 5'b00000, 3'b000, 0, 0, 0, 0, 0, 0);
    mem_PCSrc = 1;
    cyc("mw_br", M_EN, 5'b00000, 3'b000, 0, 0, 0, 0, 0, 0);
    mem_PCSrc = 0; dmem_ready = 1;
    cyc("mw_done", M_EN | M_SC, 5'b11111, 3'b000, 0, 0, 0, 0, 0, 16'd5);
    clr();

    // Halt: four advancing cycles; stall and freeze cycles do not count
    dbg_halt_req = 1;
    cyc("halt_req", M_EN | M_H, 5'b11111, 3'b000, 0, 0, 0, 0, 0, 0);
    clr();
    cyc("halting_a", M_EN | M_H, 5'b01111, 3'b100, 0, 0, 0, 0, 0, 0);
    idex_MemRead = 1; idex_RegWrite = 1; idex_WriteReg = 3; id_rs1 = 3; id_use_rs1 = 1;
    cyc("halting_lu", M_EN, 5'b00111, 3'b010, 0, 0, 0, 0, 0, 0);
    clr(); dmem_req = 1;
    cyc("halting_mw", M_EN | M_H, 5'b00000, 3'b000, 0, 0, 0, 0, 0, 0);
    clr();
    cyc("halting_b", M_EN | M_H, 5'b01111, 3'b100, 0, 0, 0, 0, 0, 0);
    cyc("halting_c", M_EN | M_H, 5'b01111, 3'b100, 0, 0, 0, 0, 0, 0);
    cyc("halting_d", M_EN | M_H, 5'b01111, 3'b100, 0, 0, 0, 0, 0, 0);
    cyc("halted", M_EN | M_H | M_SC, 5'b00000, 3'b000, 0, 0, 0, 0, 1, 16'd5);

    // Step: one fetch cycle, then four drain cycles before halted returns
    dbg_step_req = 1;
    cyc("step_req", M_EN | M_H, 5'b00000, 3'b000, 0, 0, 0, 0, 1, 0);
    dbg_step_req = 0;
    cyc("step", M_EN | M_H, 5'b11111, 3'b000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc("step_drain", M_EN | M_H, 5'b01111, 3'b100, 0, 0, 0, 0, 0, 0);
    cyc("rehalted", M_EN | M_H, 5'b00000, 3'b000, 0, 0, 0, 0, 1, 0);

    // Resume and step together: resume wins
    dbg_resume_req = 1; dbg_step_req = 1;
    cyc("res_step", M_EN | M_H, 5'b00000, 3'b000, 0, 0, 0, 0, 1, 0);
    clr();
    cyc("resumed", M_EN | M_H, 5'b11111, 3'b000, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset while HALTING with drain counter at 2
    dbg_halt_req = 1;
    cyc("halt2", M_EN, 5'b11111, 3'b000, 0, 0, 0, 0, 0, 0);
    clr();
    cyc("h2_cnt0", M_EN, 5'b01111, 3'b100, 0, 0, 0, 0, 0, 0);
    cyc("h2_cnt1", M_EN, 5'b01111, 3'b100, 0, 0, 0, 0, 0, 0);
    push("h2_cnt2", M_EN | M_H | M_SC, 5'b01111, 3'b100, 0, 0, 0, 0, 0, 16'd5);
    @(negedge clk); #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    cyc("post_reset", 4'b1111, 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0, 0, 16'd0);

    @(posedge clk); #1;
    cmp("queue_drained", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
